// File: rtl/pool_ctrl.sv
// pool_ctrl: sequencer for the 2x2 max-pooling line buffer and max tree.
// Define POOL_CTRL_STRIDE1_EN to add cfg_stride1 (overlapping stride-1 windows).
`ifndef ADDR_FIFO
`define ADDR_FIFO 8
`endif

module pool_ctrl #(
    parameter int PIPE_LAT   = 3,
    parameter int CLR_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [`ADDR_FIFO-1:0] cfg_row_len,
    input  logic [`ADDR_FIFO-1:0] cfg_num_rows,
`ifdef POOL_CTRL_STRIDE1_EN
    input  logic                  cfg_stride1,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  shifting_line,
    output logic                  line_buffer_reset,
    output logic                  pool_enable,
    output logic [`ADDR_FIFO-1:0] row_length,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int AW = `ADDR_FIFO;
    localparam logic [AW-1:0] ONE = AW'(1);
    localparam logic [AW-1:0] TWO = AW'(2);
    localparam logic [7:0] CLR_LAST = 8'(CLR_CYCLES - 1);
    localparam logic [7:0] DRN_LAST = 8'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_nxt;
    logic [7:0]          cnt_r;
    logic [AW-1:0]       num_rows_r;
    logic [AW-1:0]       col_r;
    logic [AW-1:0]       row_r;
    logic [PIPE_LAT-1:0] vsr_r;
    logic                cfg_bad_s;
    logic                good_start_s;
    logic                accept_s;
    logic                col_last_s;
    logic                last_pix_s;
    logic                win_s;

    assign cfg_bad_s     = (cfg_row_len < TWO) || (cfg_num_rows < TWO);
    assign good_start_s  = (state_r == S_IDLE) && start && !cfg_bad_s;
    assign accept_s      = in_valid && in_ready;
    assign shifting_line = accept_s;
    assign col_last_s    = (col_r == (row_length - ONE));
    assign last_pix_s    = col_last_s && (row_r == (num_rows_r - ONE));
    assign out_valid     = vsr_r[PIPE_LAT-1];

`ifdef POOL_CTRL_STRIDE1_EN
    logic stride1_r;

    // Stride mode latched with the rest of the map configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stride1_r <= 1'b0;
        end else if (good_start_s) begin
            stride1_r <= cfg_stride1;
        end else begin
            stride1_r <= stride1_r;
        end
    end

    assign win_s = stride1_r ? ((row_r != {AW{1'b0}}) && (col_r != {AW{1'b0}}))
                             : (row_r[0] && col_r[0]);
`else
    assign win_s = row_r[0] && col_r[0];
`endif

    // Next-state decode.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (cfg_bad_s) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_CLEAR;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (cnt_r == CLR_LAST) begin
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_CLEAR;
                end
            end
            S_RUN: begin
                if (accept_s && last_pix_s) begin
                    state_nxt = S_DRAIN;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                if (cnt_r == DRN_LAST) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, phase counter and state-decoded registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r           <= S_IDLE;
            cnt_r             <= 8'd0;
            in_ready          <= 1'b0;
            line_buffer_reset <= 1'b0;
            pool_enable       <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            state_r           <= state_nxt;
            cnt_r             <= (state_nxt != state_r) ? 8'd0 : (cnt_r + 8'd1);
            in_ready          <= (state_nxt == S_RUN);
            line_buffer_reset <= (state_nxt == S_CLEAR);
            pool_enable       <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            busy              <= (state_nxt != S_IDLE);
            done              <= (state_nxt == S_DONE);
        end
    end

    // A bad start raises err; any good start clears it; starts while busy are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err        <= 1'b0;
            row_length <= {AW{1'b0}};
            num_rows_r <= {AW{1'b0}};
        end else if ((state_r == S_IDLE) && start) begin
            err <= cfg_bad_s;
            if (!cfg_bad_s) begin
                row_length <= cfg_row_len;
                num_rows_r <= cfg_num_rows;
            end else begin
                row_length <= row_length;
                num_rows_r <= num_rows_r;
            end
        end else begin
            err        <= err;
            row_length <= row_length;
            num_rows_r <= num_rows_r;
        end
    end

    // Pixel position of the next accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r <= {AW{1'b0}};
            row_r <= {AW{1'b0}};
        end else if (good_start_s) begin
            col_r <= {AW{1'b0}};
            row_r <= {AW{1'b0}};
        end else if (accept_s) begin
            if (col_last_s) begin
                col_r <= {AW{1'b0}};
                row_r <= last_pix_s ? {AW{1'b0}} : (row_r + ONE);
            end else begin
                col_r <= col_r + ONE;
                row_r <= row_r;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // Valid bits ride alongside the max-tree pipeline; one slot per enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsr_r <= {PIPE_LAT{1'b0}};
        end else if (good_start_s) begin
            vsr_r <= {PIPE_LAT{1'b0}};
        end else if (pool_enable) begin
            vsr_r <= {vsr_r[PIPE_LAT-2:0], (accept_s && win_s)};
        end else begin
            vsr_r <= vsr_r;
        end
    end

    pool_ctrl_chk u_chk (
        .clk               (clk),
        .rst               (rst),
        .in_ready          (in_ready),
        .shifting_line     (shifting_line),
        .line_buffer_reset (line_buffer_reset),
        .pool_enable       (pool_enable),
        .out_valid         (out_valid),
        .busy              (busy),
        .done              (done)
    );

endmodule

// Structural invariants between the decoded control outputs.
module pool_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic in_ready,
    input logic shifting_line,
    input logic line_buffer_reset,
    input logic pool_enable,
    input logic out_valid,
    input logic busy,
    input logic done
);

    a_ready_in_run: assert property (@(posedge clk) disable iff (rst)
        in_ready |-> (busy && pool_enable && !line_buffer_reset));
    a_clear_idle_pipe: assert property (@(posedge clk) disable iff (rst)
        line_buffer_reset |-> (busy && !pool_enable && !in_ready));
    a_done_quiet: assert property (@(posedge clk) disable iff (rst)
        done |-> (busy && !in_ready && !pool_enable));
    a_outv_enabled: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> pool_enable);
    a_shift_ready: assert property (@(posedge clk) disable iff (rst)
        shifting_line |-> in_ready);

endmodule
